cpu_bus_responder: RTL



---
 rtl/bus_defs_pkg.sv | 24 ++
 rtl/cpu_bus_responder_onehot_encoder.sv | 22 ++
 rtl/cpu_bus_responder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/bus_defs_pkg.sv
// rtl/bus_defs_pkg.sv - shared CPU bus state encoding, error data and target map
package bus_defs;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIXED = 2'd1,
        WAIT_READY = 2'd2,
        RESPOND    = 2'd3
    } bus_state_t;

    localparam logic [31:0] BUS_ERROR_RDATA = 32'hFFFF_FFFF;

    localparam int TGT_RAM        = 0;
    localparam int TGT_VDP        = 1;
    localparam int TGT_STATUS     = 2;
    localparam int TGT_DSP        = 3;
    localparam int TGT_PAD        = 4;
    localparam int TGT_COP_RAM    = 5;
    localparam int TGT_BOOT       = 6;
    localparam int TGT_FLASH_CTRL = 7;
    localparam int TGT_AUDIO      = 8;
    localparam int TGT_FLASH_READ = 9;

endpackage

// File: rtl/cpu_bus_responder_onehot_encoder.sv
// rtl/cpu_bus_responder_onehot_encoder.sv - one-hot select to index plus one-hot validity flag
module onehot_encoder #(
    parameter int WIDTH = 10,
    parameter int IDX_W = 4
) (
    input  logic [WIDTH-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             valid_onehot
);

    // OR together the indices of set bits; only meaningful when exactly one bit is set
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        valid_onehot = $onehot(onehot);
    end

endmodule

// File: rtl/cpu_bus_responder.sv
// rtl/cpu_bus_responder.sv - CPU bus ready/rdata return path; BUS_TIMEOUT_EN adds a WAIT_READY timeout
module cpu_bus_responder
    import bus_defs::*;
#(
    parameter int                       NUM_TARGETS   = 10,
    parameter logic [4*NUM_TARGETS-1:0] TARGET_WAIT   = 40'h00_0000_0000,
    parameter logic [NUM_TARGETS-1:0]   VARIABLE_MASK = 10'b11_0000_0000
`ifdef BUS_TIMEOUT_EN
    ,
    parameter int                       TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cpu_mem_valid,
    input  logic [3:0]               cpu_wstrb,
    input  logic [NUM_TARGETS-1:0]   target_sel,
    input  logic [32*NUM_TARGETS-1:0] target_rdata,
    input  logic [NUM_TARGETS-1:0]   target_ready,
    output logic                     cpu_mem_ready,
    output logic [31:0]              cpu_rdata,
    output logic                     bus_error,
    output logic                     busy
);

    localparam int IDX_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;

    bus_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             is_write_q, is_write_d;
    logic [3:0]       count_q, count_d;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_valid;
    logic [3:0]       sel_wait;
    logic             sel_var;
    logic             lat_ready;
    logic [31:0]      sel_rdata;
    logic             resp_err;
    logic             ready_d, err_d, busy_d;
    logic [31:0]      rdata_d;

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tcount_q, tcount_d;
`endif

    onehot_encoder #(
        .WIDTH (NUM_TARGETS),
        .IDX_W (IDX_W)
    ) u_sel_enc (
        .onehot       (target_sel),
        .idx          (enc_idx),
        .valid_onehot (enc_valid)
    );

    // Per-target lookups: wait count and latency class for the new request, ready of the latched target
    always_comb begin
        sel_wait  = 4'd0;
        sel_var   = 1'b0;
        lat_ready = 1'b0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            if (enc_idx == IDX_W'(i)) begin
                sel_wait = TARGET_WAIT[4*i +: 4];
                sel_var  = VARIABLE_MASK[i];
            end
            if (idx_q == IDX_W'(i)) begin
                lat_ready = target_ready[i];
            end
        end
    end

    // Read data mux driven by the index that will be latched this cycle
    always_comb begin
        sel_rdata = 32'h0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                sel_rdata = target_rdata[32*i +: 32];
            end
        end
    end

    // State and transaction context registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            is_write_q <= 1'b0;
            count_q    <= 4'd0;
`ifdef BUS_TIMEOUT_EN
            tcount_q   <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            is_write_q <= is_write_d;
            count_q    <= count_d;
`ifdef BUS_TIMEOUT_EN
            tcount_q   <= tcount_d;
`endif
        end
    end

    // Next-state logic; an abort (valid dropped) wins over a same-cycle completion
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        is_write_d = is_write_q;
        count_d    = count_q;
        resp_err   = 1'b0;
`ifdef BUS_TIMEOUT_EN
        tcount_d   = tcount_q;
`endif
        case (state_q)
            IDLE: begin
                if (cpu_mem_valid) begin
                    idx_d      = enc_idx;
                    is_write_d = |cpu_wstrb;
                    if (!enc_valid) begin
                        state_d  = RESPOND;
                        resp_err = 1'b1;
                    end else if (sel_var) begin
                        state_d = WAIT_READY;
`ifdef BUS_TIMEOUT_EN
                        tcount_d = 8'd0;
`endif
                    end else begin
                        count_d = sel_wait;
                        state_d = (sel_wait == 4'd0) ? RESPOND : WAIT_FIXED;
                    end
                end
            end
            WAIT_FIXED: begin
                if (!cpu_mem_valid) begin
                    state_d = IDLE;
                    count_d = 4'd0;
                end else begin
                    count_d = count_q - 4'd1;
                    if (count_q == 4'd1) begin
                        state_d = RESPOND;
                    end
                end
            end
            WAIT_READY: begin
                if (!cpu_mem_valid) begin
                    state_d = IDLE;
                end else if (lat_ready) begin
                    state_d = RESPOND;
`ifdef BUS_TIMEOUT_EN
                end else if (tcount_q == TIMEOUT_LAST) begin
                    state_d  = RESPOND;
                    resp_err = 1'b1;
                end else begin
                    tcount_d = tcount_q + 8'd1;
`endif
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs; rdata is captured only on entry to RESPOND
    always_comb begin
        ready_d = (state_d == RESPOND);
        err_d   = resp_err;
        busy_d  = (state_d != IDLE);
        rdata_d = cpu_rdata;
        if (state_d == RESPOND) begin
            if (resp_err) begin
                rdata_d = BUS_ERROR_RDATA;
            end else if (is_write_d) begin
                rdata_d = 32'h0;
            end else begin
                rdata_d = sel_rdata;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_mem_ready <= 1'b0;
            cpu_rdata     <= 32'h0;
            bus_error     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            cpu_mem_ready <= ready_d;
            cpu_rdata     <= rdata_d;
            bus_error     <= err_d;
            busy          <= busy_d;
        end
    end

endmodule
